ddc_edid_slave: RTL and testbench
=================================

DDC_EDID_SLAVE -- requirements
Module: ddc_edid_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit I2C address (0xA0 write / 0xA1 read).
REQ-002 SHALL have parameter FILTER_LEN, default 3, the clk cycles an scl_i/sda_i level must be stable before it is accepted.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port nReset, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port scl_i, input, 1, the raw DDC SCL pad level.
REQ-006 SHALL have port sda_i, input, 1, the raw DDC SDA pad level.
REQ-007 SHALL have port sda_oen, output, 1, the SDA output enable: 0 drives low, 1 releases; the pad driver ties data to 0.
REQ-008 SHALL have port mem_addr, output, 8, the current byte offset into EDID memory.
REQ-009 SHALL have port mem_rdata, input, 8, the memory read data, valid one clk after mem_addr changes.
REQ-010 SHALL have port mem_wdata, output, 8, the received data byte.
REQ-011 SHALL have port mem_we, output, 1, a one-clk write strobe.
REQ-012 SHALL have port busy, output, 1, high from an address-matched START until the next STOP or NACK termination.

Function
REQ-013 SHALL pass scl_i and sda_i through a 2-flop synchronizer, then a FILTER_LEN stability filter; all edge detection uses filtered levels.
REQ-014 SHALL detect START as filtered SDA falling while SCL is high, and STOP as SDA rising while SCL is high; both are honoured in every state.
REQ-015 SHALL sample SDA on SCL rising edges and change sda_oen only within 1 clk after an SCL falling edge; the block never stretches SCL.
REQ-016 SHALL implement states IDLE, ADDR, ADDR_ACK, OFFSET, OFFSET_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-017 SHALL go IDLE→ADDR on START, and on a repeated START from any state go to ADDR with the bit counter cleared.
REQ-018 SHALL, after 8 ADDR bits, ACK only on a match with SLAVE_ADDR; on a mismatch it SHALL release SDA and return to IDLE.
REQ-019 SHALL, on a matched write (R/W=0), go ADDR_ACK→OFFSET; the received byte loads the offset and is ACKed in OFFSET_ACK; the block then moves to WDATA.
REQ-020 SHALL, on a matched read (R/W=1), load the read shifter from mem_rdata at the ADDR_ACK SCL falling edge, increment the offset, and shift MSB first in RDATA.
REQ-021 SHALL, in RDATA_ACK, sample the master bit: on ACK (0) it loads the next byte and increments the offset; on NACK (1) it releases SDA and goes IDLE.
REQ-022 SHALL perform offset arithmetic modulo 256: 0xFF+1 wraps to 0x00, with no NACK at the wrap.
REQ-023 SHALL keep mem_addr equal to the offset register at all times.
REQ-024 SHALL hold mem_we at 0 when the write feature is compiled out (REQ-030).
REQ-025 SHALL, on STOP, release SDA, go to IDLE and drop busy on the next clk, leaving the offset unchanged.
REQ-026 SHALL, when START and STOP are detected in the same clk (glitch), treat it as STOP.

Reset
REQ-027 SHALL, with nReset low, asynchronously force state IDLE, sda_oen=1, mem_addr=0x00, mem_wdata=0x00, mem_we=0, busy=0, synchronizer/filter registers=1, and bit counter=0.
REQ-028 SHALL, when nReset asserts mid-transfer, release SDA immediately with no further ACK or data driven.
REQ-029 SHALL, after nReset deasserts, ignore the bus until the first START.

Configuration
REQ-030 SHALL support macro DDC_WRITE_EN. Defined: each WDATA byte is ACKed, and at its 8th SCL rising edge mem_wdata is set and mem_we pulses for 1 clk, then the offset increments. Undefined: WDATA bytes are NACKed (SDA released in WDATA_ACK), mem_we stays 0, the offset is unchanged, and the block returns to IDLE.

Verification
REQ-031 SHALL pass: reset, write 0xA0, offset 0x10, repeated START, read 0xA1, 3 bytes with ACK,ACK,NACK, memory[n]=n → bus data 0x10,0x11,0x12, and mem_addr=0x13 after STOP.
REQ-032 SHALL pass: address 0xA4 → no ACK (SDA high at 9th clock), busy stays 0, and mem_addr is unchanged.
REQ-033 SHALL pass: offset 0xFE, read 4 bytes → 0xFE,0xFF,0x00,0x01, and mem_addr=0x02.
REQ-034 SHALL pass with DDC_WRITE_EN: write 0xA0,0x20,0xAB,0xCD → mem_we pulses twice with (0x20,0xAB),(0x21,0xCD); without it → 0xAB is NACKed and mem_we stays 0.
REQ-035 SHALL pass: nReset pulsed low during bit 4 of a read byte → sda_oen=1 within the reset, state IDLE, and the next full transaction succeeds.
REQ-036 SHALL pass: a 1-clk SDA glitch while SCL is high with FILTER_LEN=3 → no START/STOP is detected and the state is unchanged.

Source files
------------

// File: rtl/ddc_edid_slave.sv
// DDC/EDID I2C slave: synchronised and filtered SCL/SDA, byte-offset read path, optional write path.
// Build option: define DDC_WRITE_EN to ACK and store write-data bytes; otherwise they are NACKed.
module ddc_edid_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oen,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, OFFSET, OFFSET_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    localparam int            CW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] FMAX = CW'(FILTER_LEN - 1);

    // Index 1 carries SCL, index 0 carries SDA through every input stage.
    logic [1:0]    meta, sync, filt, prev;
    logic [CW-1:0] fcnt [2];

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            meta    <= 2'b11;
            sync    <= 2'b11;
            filt    <= 2'b11;
            prev    <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            meta <= {scl_i, sda_i};
            sync <= meta;
            prev <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FMAX) begin
                    filt[i] <= sync[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + CW'(1);
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    assign scl_f     = filt[1];
    assign sda_f     = filt[0];
    assign scl_rise  = filt[1] & ~prev[1];
    assign scl_fall  = ~filt[1] & prev[1];
    assign start_det = filt[1] & prev[1] & prev[0] & ~filt[0];
    assign stop_det  = filt[1] & prev[1] & ~prev[0] & filt[0];

    state_t     state, state_d;
    logic [3:0] bit_cnt, bit_cnt_d;
    logic [7:0] shift, shift_d, offset, offset_d, wdata_d;
    logic       sda_oen_d, busy_d, ack, ack_d, we_d;

    assign mem_addr = offset;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            offset    <= '0;
            sda_oen   <= 1'b1;
            busy      <= 1'b0;
            ack       <= 1'b1;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            shift     <= shift_d;
            offset    <= offset_d;
            sda_oen   <= sda_oen_d;
            busy      <= busy_d;
            ack       <= ack_d;
            mem_wdata <= wdata_d;
            mem_we    <= we_d;
        end
    end

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        offset_d  = offset;
        sda_oen_d = sda_oen;
        busy_d    = busy;
        ack_d     = ack;
        wdata_d   = mem_wdata;
        we_d      = 1'b0;
`ifdef DDC_WRITE_EN
        // The offset advances the clk after the strobe so the write sees the old address.
        if (mem_we) offset_d = offset + 8'd1;
`endif
        if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_oen_d = 1'b1;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oen_d = 1'b1;
        end else begin
            case (state)
                IDLE: ;
                ADDR, OFFSET, WDATA: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shift_d   = {shift[6:0], sda_f};
                        bit_cnt_d = bit_cnt + 4'd1;
`ifdef DDC_WRITE_EN
                        if (state == WDATA && bit_cnt == 4'd7) begin
                            wdata_d = {shift[6:0], sda_f};
                            we_d    = 1'b1;
                        end
`endif
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_d = '0;
                        if (state == ADDR) begin
                            if (shift[7:1] == SLAVE_ADDR) begin
                                sda_oen_d = 1'b0;
                                busy_d    = 1'b1;
                                state_d   = ADDR_ACK;
                            end else begin
                                sda_oen_d = 1'b1;
                                busy_d    = 1'b0;
                                state_d   = IDLE;
                            end
                        end else if (state == OFFSET) begin
                            offset_d  = shift;
                            sda_oen_d = 1'b0;
                            state_d   = OFFSET_ACK;
                        end else begin
`ifdef DDC_WRITE_EN
                            sda_oen_d = 1'b0;
`else
                            sda_oen_d = 1'b1;
`endif
                            state_d   = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    bit_cnt_d = '0;
                    if (shift[0]) begin
                        shift_d   = mem_rdata;
                        sda_oen_d = mem_rdata[7];
                        offset_d  = offset + 8'd1;
                        state_d   = RDATA;
                    end else begin
                        sda_oen_d = 1'b1;
                        state_d   = OFFSET;
                    end
                end
                OFFSET_ACK: if (scl_fall) begin
                    sda_oen_d = 1'b1;
                    state_d   = WDATA;
                end
                WDATA_ACK: if (scl_fall) begin
                    sda_oen_d = 1'b1;
`ifdef DDC_WRITE_EN
                    state_d   = WDATA;
`else
                    busy_d    = 1'b0;
                    state_d   = IDLE;
`endif
                end
                RDATA: if (scl_fall) begin
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_d = '0;
                        sda_oen_d = 1'b1;
                        state_d   = RDATA_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt + 4'd1;
                        shift_d   = {shift[6:0], 1'b0};
                        sda_oen_d = shift[6];
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) ack_d = sda_f;
                    if (scl_fall) begin
                        if (!ack) begin
                            shift_d   = mem_rdata;
                            sda_oen_d = mem_rdata[7];
                            offset_d  = offset + 8'd1;
                            state_d   = RDATA;
                        end else begin
                            sda_oen_d = 1'b1;
                            busy_d    = 1'b0;
                            state_d   = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddc_edid_slave.sv
// Bench for ddc_edid_slave: bit-banged DDC master, EDID memory model, scoreboard queues for read data and writes.
module tb_ddc_edid_slave;

    localparam int QTR = 10;

    logic       clk = 1'b0;
    logic       nReset;
    logic       scl_m, sda_m;
    logic       sda_i;
    logic       sda_oen;
    logic [7:0] mem_addr, mem_rdata, mem_wdata;
    logic       mem_we, busy;

    logic [7:0]  mem [256];
    logic [7:0]  exp_q[$];
    logic [15:0] wr_exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          we_count = 0;

    assign sda_i = sda_m & sda_oen;

    always #5 clk = ~clk;

    ddc_edid_slave #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
        .clk       (clk),
        .nReset    (nReset),
        .scl_i     (scl_m),
        .sda_i     (sda_i),
        .sda_oen   (sda_oen),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] e;
        if (nReset && mem_we) begin
            we_count++;
            if (wr_exp_q.size() != 0) e = wr_exp_q.pop_front();
            else e = ~{mem_addr, mem_wdata};
            check("mem_write", {mem_addr, mem_wdata}, e);
        end
    end

    task automatic wait_q();
        repeat (QTR) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        sda_m = b; wait_q();
        scl_m = 1'b1; wait_q();
        if (glitch) begin
            sda_m = ~b; @(negedge clk);
            sda_m = b;
        end
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        b = sda_i; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic [7:0] glitch, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i], glitch[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(ack, 1'b0);
    endtask

    task automatic set_offset(input logic [7:0] off, input logic [7:0] glitch);
        logic a;
        bus_start();
        send_byte(8'hA0, 8'h00, a);
        check("ack_addr_wr", {15'd0, a}, 16'd0);
        send_byte(off, glitch, a);
        check("ack_offset", {15'd0, a}, 16'd0);
        check("busy_in_xfer", {15'd0, busy}, 16'd1);
    endtask

    task automatic read_bytes(input int n);
        logic       a;
        logic [7:0] d;
        logic [7:0] e;
        bus_start();
        send_byte(8'hA1, 8'h00, a);
        check("ack_addr_rd", {15'd0, a}, 16'd0);
        for (int i = 0; i < n; i++) begin
            recv_byte(d, (i == n - 1));
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = ~d;
            check("rdata", {8'd0, d}, {8'd0, e});
        end
        bus_stop();
    endtask

    initial begin
        logic       a;
        logic [7:0] base;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        nReset = 1'b0;
        scl_m  = 1'b1;
        sda_m  = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_sda_oen", {15'd0, sda_oen}, 16'd1);
        check("rst_mem_addr", {8'd0, mem_addr}, 16'h0000);
        check("rst_mem_wdata", {8'd0, mem_wdata}, 16'h0000);
        check("rst_mem_we", {15'd0, mem_we}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        nReset = 1'b1;
        wait_q();

        // offset 0x10, repeated START, three bytes read with ACK,ACK,NACK
        base = 8'h10;
        set_offset(base, 8'h00);
        for (int i = 0; i < 3; i++) exp_q.push_back(base + 8'(i));
        read_bytes(3);
        wait_q();
        check("addr_after_read", {8'd0, mem_addr}, 16'h0013);
        check("busy_after_stop", {15'd0, busy}, 16'd0);

        // foreign address is not acknowledged
        bus_start();
        send_byte(8'hA4, 8'h00, a);
        check("nack_foreign", {15'd0, a}, 16'd1);
        check("busy_foreign", {15'd0, busy}, 16'd0);
        bus_stop();
        check("addr_foreign", {8'd0, mem_addr}, 16'h0013);

        // offset wrap through 0xFF
        base = 8'hFE;
        set_offset(base, 8'h00);
        for (int i = 0; i < 4; i++) exp_q.push_back(base + 8'(i));
        read_bytes(4);
        wait_q();
        check("addr_after_wrap", {8'd0, mem_addr}, 16'h0002);

        // write data bytes
        set_offset(8'h20, 8'h00);
`ifdef DDC_WRITE_EN
        wr_exp_q.push_back(16'h20AB);
        send_byte(8'hAB, 8'h00, a);
        check("ack_wdata0", {15'd0, a}, 16'd0);
        wr_exp_q.push_back(16'h21CD);
        send_byte(8'hCD, 8'h00, a);
        check("ack_wdata1", {15'd0, a}, 16'd0);
        bus_stop();
        wait_q();
        check("we_count", 16'(we_count), 16'd2);
        check("addr_after_write", {8'd0, mem_addr}, 16'h0022);
`else
        send_byte(8'hAB, 8'h00, a);
        check("nack_wdata", {15'd0, a}, 16'd1);
        check("busy_after_wnack", {15'd0, busy}, 16'd0);
        bus_stop();
        wait_q();
        check("we_count", 16'(we_count), 16'd0);
        check("addr_after_write", {8'd0, mem_addr}, 16'h0020);
`endif

        // reset asserted during bit 4 of a read byte
        set_offset(8'h30, 8'h00);
        bus_start();
        send_byte(8'hA1, 8'h00, a);
        check("ack_addr_rd_rst", {15'd0, a}, 16'd0);
        for (int i = 0; i < 3; i++) recv_bit(a);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        nReset = 1'b0;
        #1;
        check("midrst_sda_oen", {15'd0, sda_oen}, 16'd1);
        @(negedge clk);
        check("midrst_busy", {15'd0, busy}, 16'd0);
        check("midrst_mem_addr", {8'd0, mem_addr}, 16'h0000);
        repeat (3) @(negedge clk);
        nReset = 1'b1;
        wait_q(); wait_q();
        check("postrst_sda_oen", {15'd0, sda_oen}, 16'd1);
        base = 8'h05;
        set_offset(base, 8'h00);
        for (int i = 0; i < 2; i++) exp_q.push_back(base + 8'(i));
        read_bytes(2);
        wait_q();
        check("addr_after_rst_xfer", {8'd0, mem_addr}, 16'h0007);

        // one-clk SDA glitches while SCL is high: STOP-shaped on bit 7, START-shaped on bit 6
        base = 8'h40;
        set_offset(base, 8'hC0);
        exp_q.push_back(base);
        read_bytes(1);
        wait_q();
        check("addr_after_glitch", {8'd0, mem_addr}, 16'h0041);

        check("exp_q_empty", 16'(exp_q.size()), 16'd0);
        check("wr_exp_q_empty", 16'(wr_exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
